// File: rtl/div_ctrl_pkg.sv
// Shared encodings for the M-extension divide sequencer and its sign-fix helper.
package div_ctrl_pkg;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    FIXUP = 3'd3,
    RESP  = 3'd4
  } state_e;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Combinational sign handling around the unsigned divider core:
// operand magnitudes, result negation and RISC-V special-case detection.
module div_sign_fix
  import div_ctrl_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [31:0] q_raw,
  input  logic [31:0] r_raw,
  input  logic        quo_neg,
  input  logic        rem_neg,
  output logic [31:0] abs_a,
  output logic [31:0] abs_b,
  output logic        quo_neg_req,
  output logic        rem_neg_req,
  output logic        special,
  output logic [31:0] special_data,
  output logic [31:0] q_fix,
  output logic [31:0] r_fix
);

  logic is_signed;
  logic sign_a;
  logic sign_b;
  logic div_zero;
  logic overflow;

  always_comb begin
    is_signed   = (op == OP_DIV) || (op == OP_REM);
    sign_a      = is_signed & rs1[31];
    sign_b      = is_signed & rs2[31];
    abs_a       = sign_a ? neg32(rs1) : rs1;
    abs_b       = sign_b ? neg32(rs2) : rs2;
    quo_neg_req = sign_a ^ sign_b;
    rem_neg_req = sign_a;

    // Divide-by-zero takes precedence; overflow only exists for signed ops.
    div_zero     = (rs2 == 32'd0);
    overflow     = is_signed && (rs1 == INT_MIN) && (rs2 == 32'hFFFF_FFFF);
    special      = div_zero | overflow;
    special_data = 32'd0;
    if (div_zero) begin
      special_data = op[1] ? rs1 : 32'hFFFF_FFFF;
    end else if (overflow) begin
      special_data = op[1] ? 32'd0 : INT_MIN;
    end

    q_fix = quo_neg ? neg32(q_raw) : q_raw;
    r_fix = rem_neg ? neg32(r_raw) : r_raw;
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// Execute-stage sequencer driving a shared unsigned restoring divider core,
// with RISC-V DIV/DIVU/REM/REMU semantics and a one-entry q/r reuse register.
module div_seq_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int CACHE_EN = 1
) (
  input  logic            clk,
  input  logic            rstLow,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            core_start,
  output logic [XLEN-1:0] core_a,
  output logic [XLEN-1:0] core_b,
  input  logic            core_busy,
  input  logic [XLEN-1:0] core_q,
  input  logic [XLEN-1:0] core_r
);

  localparam bit UseCache = (CACHE_EN != 0);

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic            quo_neg_q, quo_neg_d;
  logic            rem_neg_q, rem_neg_d;
  logic [XLEN-1:0] core_a_q, core_a_d;
  logic [XLEN-1:0] core_b_q, core_b_d;
  logic [XLEN-1:0] q_raw_q, q_raw_d;
  logic [XLEN-1:0] r_raw_q, r_raw_d;
  logic [XLEN-1:0] resp_data_q, resp_data_d;
  logic            c_valid_q, c_valid_d;
  logic [XLEN-1:0] c_rs1_q, c_rs1_d;
  logic [XLEN-1:0] c_rs2_q, c_rs2_d;
  logic            c_uns_q, c_uns_d;
  logic [XLEN-1:0] c_quo_q, c_quo_d;
  logic [XLEN-1:0] c_rem_q, c_rem_d;

  logic [XLEN-1:0] abs_a, abs_b, special_data, q_fix, r_fix;
  logic            quo_neg_req, rem_neg_req, special;
  logic            accept, cache_hit;

  div_sign_fix u_sign_fix (
    .op           (req_op),
    .rs1          (req_rs1),
    .rs2          (req_rs2),
    .q_raw        (q_raw_q),
    .r_raw        (r_raw_q),
    .quo_neg      (quo_neg_q),
    .rem_neg      (rem_neg_q),
    .abs_a        (abs_a),
    .abs_b        (abs_b),
    .quo_neg_req  (quo_neg_req),
    .rem_neg_req  (rem_neg_req),
    .special      (special),
    .special_data (special_data),
    .q_fix        (q_fix),
    .r_fix        (r_fix)
  );

  // Ready is gated by reset so it reads 0 while rstLow is asserted.
  assign req_ready  = rstLow && (state_q == IDLE) && !core_busy;
  assign resp_valid = (state_q == RESP);
  assign resp_data  = resp_data_q;
  assign core_start = (state_q == ISSUE);
  assign core_a     = core_a_q;
  assign core_b     = core_b_q;

  assign accept    = req_valid && req_ready && !flush;
  assign cache_hit = UseCache && c_valid_q && (c_rs1_q == req_rs1) &&
                     (c_rs2_q == req_rs2) && (c_uns_q == req_op[0]);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    quo_neg_d   = quo_neg_q;
    rem_neg_d   = rem_neg_q;
    core_a_d    = core_a_q;
    core_b_d    = core_b_q;
    q_raw_d     = q_raw_q;
    r_raw_d     = r_raw_q;
    resp_data_d = resp_data_q;
    c_valid_d   = c_valid_q;
    c_rs1_d     = c_rs1_q;
    c_rs2_d     = c_rs2_q;
    c_uns_d     = c_uns_q;
    c_quo_d     = c_quo_q;
    c_rem_d     = c_rem_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d      = req_op;
          rs1_d     = req_rs1;
          rs2_d     = req_rs2;
          quo_neg_d = quo_neg_req;
          rem_neg_d = rem_neg_req;
          if (special) begin
            resp_data_d = special_data;
            state_d     = RESP;
          end else if (cache_hit) begin
            resp_data_d = req_op[1] ? c_rem_q : c_quo_q;
            state_d     = RESP;
          end else begin
            core_a_d = abs_a;
            core_b_d = abs_b;
            state_d  = ISSUE;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (!core_busy) begin
          q_raw_d = core_q;
          r_raw_d = core_r;
          state_d = FIXUP;
        end
      end
      FIXUP: begin
        resp_data_d = op_q[1] ? r_fix : q_fix;
        c_valid_d   = UseCache;
        c_rs1_d     = rs1_q;
        c_rs2_d     = rs2_q;
        c_uns_d     = op_q[0];
        c_quo_d     = q_fix;
        c_rem_d     = r_fix;
        state_d     = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Flush beats everything, including a same-cycle response handshake.
    if (flush) begin
      state_d   = IDLE;
      c_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstLow) begin
    if (!rstLow) begin
      state_q     <= IDLE;
      op_q        <= 2'b00;
      rs1_q       <= '0;
      rs2_q       <= '0;
      quo_neg_q   <= 1'b0;
      rem_neg_q   <= 1'b0;
      core_a_q    <= '0;
      core_b_q    <= '0;
      q_raw_q     <= '0;
      r_raw_q     <= '0;
      resp_data_q <= '0;
      c_valid_q   <= 1'b0;
      c_rs1_q     <= '0;
      c_rs2_q     <= '0;
      c_uns_q     <= 1'b0;
      c_quo_q     <= '0;
      c_rem_q     <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      quo_neg_q   <= quo_neg_d;
      rem_neg_q   <= rem_neg_d;
      core_a_q    <= core_a_d;
      core_b_q    <= core_b_d;
      q_raw_q     <= q_raw_d;
      r_raw_q     <= r_raw_d;
      resp_data_q <= resp_data_d;
      c_valid_q   <= c_valid_d;
      c_rs1_q     <= c_rs1_d;
      c_rs2_q     <= c_rs2_d;
      c_uns_q     <= c_uns_d;
      c_quo_q     <= c_quo_d;
      c_rem_q     <= c_rem_d;
    end
  end

endmodule
